// File: rtl/inst_fetch_queue_if.sv
// IF->ID fetch queue bundle: fetch push side, decode pop lanes, status.
// master drives push/pop_take/flush; slave is the queue itself.
interface inst_fetch_queue_if #(
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 32,
  parameter int EXC_W   = 4,
  parameter int ISSUE_W = 2
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                       flush;
  logic                       push_valid;
  logic                       push_ready;
  logic [31:0]                push_pc;
  logic [DATA_W-1:0]          push_instr;
  logic [EXC_W-1:0]           push_exc;
  logic [ISSUE_W-1:0]         pop_valid;
  logic [32*ISSUE_W-1:0]      pop_pc;
  logic [DATA_W*ISSUE_W-1:0]  pop_instr;
  logic [EXC_W*ISSUE_W-1:0]   pop_exc;
  logic [ISSUE_W-1:0]         pop_take;
  logic [CNT_W-1:0]           count;
  logic                       almost_full;

  modport master (
    output flush, push_valid, push_pc, push_instr, push_exc, pop_take,
    input  push_ready, pop_valid, pop_pc, pop_instr, pop_exc,
    input  count, almost_full
  );

  modport slave (
    input  flush, push_valid, push_pc, push_instr, push_exc, pop_take,
    output push_ready, pop_valid, pop_pc, pop_instr, pop_exc,
    output count, almost_full
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Circular IF->ID instruction queue, one push and up to ISSUE_W pops per cycle.
// Define IFQ_BYPASS_EN for a zero-latency push->lane0 path when empty.
module inst_fetch_queue #(
  parameter int DEPTH     = 8,
  parameter int DATA_W    = 32,
  parameter int EXC_W     = 4,
  parameter int ISSUE_W   = 2,
  parameter int AF_MARGIN = 2
) (
  input logic               clk,
  input logic               resetn,
  inst_fetch_queue_if.slave ifq
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 32 + DATA_W + EXC_W;

  logic [ENT_W-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               af;
  logic [ISSUE_W-1:0] q_valid;
  logic [CNT_W-1:0]   n;
  logic               run;
  logic               byp;
  logic               byp_take;
  logic               push_en;

`ifdef IFQ_BYPASS_EN
  assign byp = (cnt == '0) & ifq.push_valid & ~ifq.flush;
`else
  assign byp = 1'b0;
`endif

  assign byp_take = byp & ifq.pop_take[0];

  assign ifq.push_ready  = cnt < CNT_W'(DEPTH);
  assign ifq.count       = cnt;
  assign ifq.almost_full = af;

  for (genvar k = 0; k < ISSUE_W; k++) begin : g_lane
    logic [PTR_W-1:0] idx;
    logic [ENT_W-1:0] ent;
    logic             lane_byp;

    assign idx      = rd_ptr + PTR_W'(k);
    assign ent      = mem[idx];
    assign lane_byp = (k == 0) ? byp : 1'b0;
    assign q_valid[k] = cnt > CNT_W'(k);

    assign ifq.pop_valid[k] = q_valid[k] | lane_byp;
    assign ifq.pop_pc[32*k +: 32] =
      lane_byp ? ifq.push_pc : ent[ENT_W-1 -: 32];
    assign ifq.pop_instr[DATA_W*k +: DATA_W] =
      lane_byp ? ifq.push_instr : ent[EXC_W +: DATA_W];
    assign ifq.pop_exc[EXC_W*k +: EXC_W] =
      lane_byp ? ifq.push_exc : ent[EXC_W-1:0];
  end

  // n counts only the leading run of taken, queue-backed lanes
  always_comb begin
    n   = '0;
    run = 1'b1;
    for (int k = 0; k < ISSUE_W; k++) begin
      if (run && ifq.pop_take[k] && q_valid[k]) begin
        n = n + CNT_W'(1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // a bypassed entry consumed the same cycle is never stored
  assign push_en = ifq.push_valid & ifq.push_ready
                 & ~ifq.flush & ~byp_take;

  always_comb begin
    cnt_nxt = cnt + CNT_W'(push_en) - n;
    if (ifq.flush) begin
      cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      af     <= 1'b0;
    end else begin
      if (ifq.flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        rd_ptr <= rd_ptr + n[PTR_W-1:0];
        wr_ptr <= wr_ptr + PTR_W'(push_en);
      end
      cnt <= cnt_nxt;
      af  <= cnt_nxt >= CNT_W'(DEPTH - AF_MARGIN);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn && push_en) begin
      mem[wr_ptr] <= {ifq.push_pc, ifq.push_instr, ifq.push_exc};
    end
  end
endmodule
